// File: rtl/fifo_rd_arb_if.sv
// Read-side bundle between one non-show-ahead FIFO, the arbiter and two consumers.
// master = arbiter, slave = FIFO/consumer environment.
interface fifo_rd_arb_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] fifo_q;
  logic              rdempty;
  logic              rdreq;
  logic [1:0]        req;
  logic [1:0]        rdy;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] dout;
  logic [1:0]        dout_vld;
  logic              busy;

  modport master (
    input  fifo_q, rdempty, req, rdy,
    output rdreq, gnt, dout, dout_vld, busy
  );

  modport slave (
    output fifo_q, rdempty, req, rdy,
    input  rdreq, gnt, dout, dout_vld, busy
  );
endinterface

// File: rtl/fifo_rd_arb.sv
// Round-robin burst arbiter sharing one FIFO read port between two consumers.
// Grants last at most BURST_LEN reads; a 1-cycle DRAIN lets the final word land.
module fifo_rd_arb #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_rd_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        vld_q, vld_d;
  logic              rdreq_w;
  logic [DATA_W-1:0] dout_w;

  // Decoded from state so it drops the same cycle a reset forces IDLE.
  assign rdreq_w = (state_q == BURST) && bus.req[sel_q] && bus.rdy[sel_q] &&
                   !bus.rdempty && (cnt_q < CNT_MAX);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    vld_d   = {rdreq_w && sel_q, rdreq_w && !sel_q};
    case (state_q)
      IDLE: begin
        if (!bus.rdempty && (bus.req != 2'b00)) begin
          sel_d   = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          gnt_d   = sel_d ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (rdreq_w) cnt_d = cnt_q + 1'b1;
        if ((rdreq_w && (cnt_q == CNT_LAST)) || !bus.req[sel_q] || bus.rdempty)
          state_d = DRAIN;
      end
      DRAIN: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = sel_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      vld_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
    end
  end

  assign dout_w       = bus.fifo_q;
  assign bus.dout     = dout_w;
  assign bus.rdreq    = rdreq_w;
  assign bus.gnt      = gnt_q;
  assign bus.dout_vld = vld_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed bench for fifo_rd_arb with a non-show-ahead FIFO model.
// Each scenario task drives its own stimulus and checks cycle-exact expectations.
module tb_fifo_rd_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  fifo_rd_arb_if #(.DATA_W(8)) ifc ();

  fifo_rd_arb #(.DATA_W(8), .BURST_LEN(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // FIFO model: q updates the edge after rdreq, empty follows pointers
  logic [7:0]  mem [64];
  logic [31:0] wptr = '0;
  logic [31:0] rptr = '0;
  assign ifc.rdempty = (rptr == wptr);

  always @(posedge clk) begin
    if (clr) rptr <= wptr;
    else if (ifc.rdreq) begin
      ifc.fifo_q <= mem[rptr[5:0]];
      rptr       <= rptr + 32'd1;
    end
  end

  logic [1:0] s_gnt, s_vld;
  logic       s_rdreq, s_busy;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         overlap;

  task automatic push(input logic [7:0] d);
    mem[wptr[5:0]] = d;
    wptr = wptr + 32'd1;
  endtask

  task automatic tick();
    @(negedge clk);
    s_gnt   = ifc.gnt;
    s_vld   = ifc.dout_vld;
    s_rdreq = ifc.rdreq;
    s_busy  = ifc.busy;
    if (s_vld[0]) q0.push_back(ifc.dout);
    if (s_vld[1]) q1.push_back(ifc.dout);
    if (s_vld == 2'b11) overlap++;
    @(posedge clk);
    #1;
  endtask

  task automatic init_test();
    rst_n = 1'b0; ifc.req = 2'b00; ifc.rdy = 2'b11; clr = 1'b1;
    tick();
    clr = 1'b0; rst_n = 1'b1;
    tick();
    q0.delete(); q1.delete(); overlap = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; ifc.req = 2'b11; ifc.rdy = 2'b11;
    push(8'h11);
    tick(); tick();
    total++;
    if ({s_busy, s_gnt, s_rdreq, s_vld} !== 6'b0) begin
      bad++; $display("FAIL reset_state got=%b want=000000", {s_busy, s_gnt, s_rdreq, s_vld});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (s_gnt !== 2'b00) begin bad++; $display("FAIL reset_idle_gnt got=%b want=00", s_gnt); end
    tick();
    total++;
    if (s_gnt !== 2'b01) begin bad++; $display("FAIL reset_first_tie got=%b want=01", s_gnt); end
    ifc.req = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_single_consumer();
    int n;
    init_test();
    for (int i = 1; i <= 20; i++) push(8'(i));
    ifc.req = 2'b01;
    tick();
    total++;
    if (s_gnt !== 2'b00) begin bad++; $display("FAIL t1_gnt_latency got=%b want=00", s_gnt); end
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (s_rdreq === 1'b1 && s_gnt === 2'b01) n++;
    end
    total++;
    if (n != 16) begin bad++; $display("FAIL t1_rdreq_run got=%0d want=16", n); end
    tick();
    total++;
    if ({s_busy, s_gnt, s_rdreq} !== 4'b1010) begin
      bad++; $display("FAIL t1_drain got=%b want=1010", {s_busy, s_gnt, s_rdreq});
    end
    tick();
    total++;
    if ({s_busy, s_gnt, s_rdreq} !== 4'b0000) begin
      bad++; $display("FAIL t1_idle got=%b want=0000", {s_busy, s_gnt, s_rdreq});
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_rdreq === 1'b1 && s_gnt === 2'b01) n++;
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL t1_second_burst got=%0d want=4", n); end
    tick();
    total++;
    if ({s_busy, s_gnt, s_rdreq} !== 4'b1010) begin
      bad++; $display("FAIL t1_empty_stop got=%b want=1010", {s_busy, s_gnt, s_rdreq});
    end
    tick(); tick();
    ifc.req = 2'b00;
    total++;
    if (q0.size() != 20 || q1.size() != 0) begin
      bad++; $display("FAIL t1_count got=%0d/%0d want=20/0", q0.size(), q1.size());
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (q0[i] !== 8'(i + 1)) begin bad++; $display("FAIL t1_data[%0d] got=%h want=%h", i, q0[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] prev;
    logic [1:0] order[$];
    int bcnt[$];
    int gaps[$];
    int zrun, onehot_err;
    bit seen;
    init_test();
    for (int i = 1; i <= 40; i++) push(8'(i));
    ifc.req = 2'b11;
    prev = 2'b00; zrun = 0; seen = 0; onehot_err = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (s_gnt == 2'b11) onehot_err++;
      if (s_gnt != 2'b00 && prev == 2'b00) begin
        order.push_back(s_gnt);
        if (seen) gaps.push_back(zrun);
        seen = 1;
        bcnt.push_back(0);
      end
      if (s_gnt == 2'b00) zrun++; else zrun = 0;
      if (s_rdreq && bcnt.size() > 0) bcnt[bcnt.size() - 1]++;
      prev = s_gnt;
    end
    ifc.req = 2'b00;
    total++;
    if (order.size() != 3 || {order[0], order[1], order[2]} !== 6'b011001) begin
      bad++; $display("FAIL t2_order n=%0d got=%b want=011001", order.size(), {order[0], order[1], order[2]});
    end
    total++;
    if (bcnt.size() != 3 || bcnt[0] != 16 || bcnt[1] != 16 || bcnt[2] != 8) begin
      bad++; $display("FAIL t2_burst_len got=%0d,%0d,%0d want=16,16,8", bcnt[0], bcnt[1], bcnt[2]);
    end
    total++;
    if (gaps.size() != 2 || gaps[0] != 1 || gaps[1] != 1) begin
      bad++; $display("FAIL t2_gap n=%0d got=%0d,%0d want=1,1", gaps.size(), gaps[0], gaps[1]);
    end
    total++;
    if (overlap != 0 || onehot_err != 0) begin
      bad++; $display("FAIL t2_exclusive overlap=%0d gnt11=%0d want=0,0", overlap, onehot_err);
    end
    total++;
    if (q0.size() != 24 || q1.size() != 16) begin
      bad++; $display("FAIL t2_count got=%0d/%0d want=24/16", q0.size(), q1.size());
    end
    for (int i = 0; i < 24; i++) begin
      total++;
      if (q0[i] !== 8'((i < 16) ? i + 1 : i + 17)) begin
        bad++; $display("FAIL t2_data0[%0d] got=%h want=%h", i, q0[i], 8'((i < 16) ? i + 1 : i + 17));
      end
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q1[i] !== 8'(i + 17)) begin bad++; $display("FAIL t2_data1[%0d] got=%h want=%h", i, q1[i], 8'(i + 17)); end
    end
  endtask

  task automatic test_backpressure();
    int nrd, first, last;
    init_test();
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    ifc.req = 2'b01;
    nrd = 0; first = -1; last = -1;
    for (int c = 0; c < 25; c++) begin
      ifc.rdy = (c >= 5 && c <= 7) ? 2'b10 : 2'b11;
      tick();
      if (s_rdreq) begin
        nrd++;
        if (first < 0) first = c;
        last = c;
      end
    end
    ifc.req = 2'b00;
    total++;
    if (nrd != 16) begin bad++; $display("FAIL t3_reads got=%0d want=16", nrd); end
    total++;
    if (first != 1 || last != 19) begin
      bad++; $display("FAIL t3_stall_window got=%0d..%0d want=1..19", first, last);
    end
    total++;
    if (q0.size() != 16) begin bad++; $display("FAIL t3_count got=%0d want=16", q0.size()); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (q0[i] !== 8'(8'h40 + i)) begin bad++; $display("FAIL t3_data[%0d] got=%h want=%h", i, q0[i], 8'(8'h40 + i)); end
    end
  endtask

  task automatic test_early_release();
    logic [1:0] glog[35];
    logic       rlog[35];
    init_test();
    for (int i = 0; i < 20; i++) push(8'(8'h80 + i));
    for (int c = 0; c < 35; c++) begin
      ifc.req = (c < 6) ? 2'b01 : 2'b10;
      tick();
      glog[c] = s_gnt;
      rlog[c] = s_rdreq;
    end
    ifc.req = 2'b00;
    total++;
    if (q0.size() != 5) begin bad++; $display("FAIL t4_vld0_pulses got=%0d want=5", q0.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (q0[i] !== 8'(8'h80 + i)) begin bad++; $display("FAIL t4_data0[%0d] got=%h want=%h", i, q0[i], 8'(8'h80 + i)); end
    end
    total++;
    if ({glog[7], rlog[7]} !== 3'b010) begin bad++; $display("FAIL t4_drain got=%b want=010", {glog[7], rlog[7]}); end
    total++;
    if (glog[8] !== 2'b00) begin bad++; $display("FAIL t4_idle_gap got=%b want=00", glog[8]); end
    total++;
    if (glog[9] !== 2'b10) begin bad++; $display("FAIL t4_regrant got=%b want=10", glog[9]); end
    total++;
    if (q1.size() != 15) begin bad++; $display("FAIL t4_vld1_pulses got=%0d want=15", q1.size()); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (q1[i] !== 8'(8'h85 + i)) begin bad++; $display("FAIL t4_data1[%0d] got=%h want=%h", i, q1[i], 8'(8'h85 + i)); end
    end
  endtask

  task automatic test_mid_reset();
    init_test();
    for (int i = 0; i < 20; i++) push(8'(8'hC0 + i));
    ifc.req = 2'b01;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ifc.req = 2'b11;
    tick();
    total++;
    if ({s_busy, s_gnt, s_rdreq, s_vld} !== 6'b0) begin
      bad++; $display("FAIL t5_after_reset got=%b want=000000", {s_busy, s_gnt, s_rdreq, s_vld});
    end
    tick();
    total++;
    if (s_gnt !== 2'b01) begin bad++; $display("FAIL t5_regrant got=%b want=01", s_gnt); end
    total++;
    if (q0.size() != 3 || q0[0] !== 8'hC0 || q0[2] !== 8'hC2) begin
      bad++; $display("FAIL t5_discard n=%0d want=3", q0.size());
    end
    ifc.req = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_empty_fifo();
    int err;
    init_test();
    ifc.req = 2'b11;
    err = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_gnt != 2'b00 || s_rdreq || s_busy) err++;
    end
    total++;
    if (err != 0) begin bad++; $display("FAIL t6_empty_hold got=%0d want=0", err); end
    push(8'hA5);
    tick();
    total++;
    if (s_gnt !== 2'b00) begin bad++; $display("FAIL t6_pre_gnt got=%b want=00", s_gnt); end
    tick();
    total++;
    if ({s_gnt, s_rdreq} !== 3'b011) begin bad++; $display("FAIL t6_gnt got=%b want=011", {s_gnt, s_rdreq}); end
    tick();
    total++;
    if (q0.size() != 1 || q0[0] !== 8'hA5) begin
      bad++; $display("FAIL t6_data n=%0d got=%h want=a5", q0.size(), q0[0]);
    end
    ifc.req = 2'b00;
    tick(); tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; ifc.req = 2'b00; ifc.rdy = 2'b00; overlap = 0;
    test_reset();
    test_single_consumer();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_mid_reset();
    test_empty_fifo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
